// File: rtl/div64by32s_seq_if.sv
// Handshake bundle for the 64/32 signed divider: operand request channel and result channel.
interface div64by32s_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        overflow;
    logic        div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/div64by32s_seq.sv
// Radix-2 restoring signed divider: 64-bit dividend by 32-bit divisor, truncating toward zero,
// with saturated quotient on overflow and a fixed 65-cycle latency from accept to result.
module div64by32s_seq (
    input  logic               clk,
    input  logic               rst_n,
    div64by32s_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] partRem_q, partRem_d;
    logic [31:0] absDivisor_q, absDivisor_d;
    logic [31:0] dividendLo_q, dividendLo_d;
    logic        signQuot_q, signQuot_d;
    logic        signRem_q, signRem_d;
    logic        divZero_q, divZero_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        overflow_q, overflow_d;
    logic        dbzOut_q, dbzOut_d;

    logic [63:0] absDividendIn;
    logic [31:0] absDivisorIn;
    logic [32:0] remShift;
    logic        trialFits;
    logic [31:0] remMag;
    logic [31:0] remSigned;

    // work_q shifts the dividend magnitude out of its MSB while quotient bits enter at the LSB,
    // so after 64 iterations it holds the full 64-bit magnitude quotient.
    always_comb begin
        absDividendIn = bus.dividend[63] ? (~bus.dividend + 64'd1) : bus.dividend;
        absDivisorIn  = bus.divisor[31]  ? (~bus.divisor + 32'd1)  : bus.divisor;
        remShift      = {partRem_q, work_q[63]};
        trialFits     = (remShift >= {1'b0, absDivisor_q});
        remMag        = partRem_q;
        remSigned     = signRem_q ? (~remMag + 32'd1) : remMag;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        work_d       = work_q;
        partRem_d    = partRem_q;
        absDivisor_d = absDivisor_q;
        dividendLo_d = dividendLo_q;
        signQuot_d   = signQuot_q;
        signRem_d    = signRem_q;
        divZero_d    = divZero_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        overflow_d   = overflow_q;
        dbzOut_d     = dbzOut_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d      = CALC;
                    cnt_d        = 6'd0;
                    work_d       = absDividendIn;
                    partRem_d    = 32'd0;
                    absDivisor_d = absDivisorIn;
                    dividendLo_d = bus.dividend[31:0];
                    signQuot_d   = bus.dividend[63] ^ bus.divisor[31];
                    signRem_d    = bus.dividend[63];
                    divZero_d    = (bus.divisor == 32'd0);
                end
            end

            CALC: begin
                // The partial remainder stays below |divisor| <= 2^31, so the 32-bit difference is exact.
                if (trialFits) begin
                    partRem_d = remShift[31:0] - absDivisor_q;
                end else begin
                    partRem_d = remShift[31:0];
                end
                work_d = {work_q[62:0], trialFits};
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                state_d = DONE;
                if (divZero_q) begin
                    quotient_d  = 32'hFFFF_FFFF;
                    remainder_d = dividendLo_q;
                    overflow_d  = 1'b0;
                    dbzOut_d    = 1'b1;
                end else begin
                    dbzOut_d    = 1'b0;
                    remainder_d = remSigned;
                    if (!signQuot_q && (work_q > 64'h0000_0000_7FFF_FFFF)) begin
                        quotient_d = 32'h7FFF_FFFF;
                        overflow_d = 1'b1;
                    end else if (signQuot_q && (work_q > 64'h0000_0000_8000_0000)) begin
                        quotient_d = 32'h8000_0000;
                        overflow_d = 1'b1;
                    end else begin
                        quotient_d = signQuot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
                        overflow_d = 1'b0;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 6'd0;
            work_q       <= 64'd0;
            partRem_q    <= 32'd0;
            absDivisor_q <= 32'd0;
            dividendLo_q <= 32'd0;
            signQuot_q   <= 1'b0;
            signRem_q    <= 1'b0;
            divZero_q    <= 1'b0;
            quotient_q   <= 32'd0;
            remainder_q  <= 32'd0;
            overflow_q   <= 1'b0;
            dbzOut_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            work_q       <= work_d;
            partRem_q    <= partRem_d;
            absDivisor_q <= absDivisor_d;
            dividendLo_q <= dividendLo_d;
            signQuot_q   <= signQuot_d;
            signRem_q    <= signRem_d;
            divZero_q    <= divZero_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            overflow_q   <= overflow_d;
            dbzOut_q     <= dbzOut_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = dbzOut_q;

endmodule

// File: tb/tb_div64by32s_seq.sv
// Directed self-checking bench for div64by32s_seq: sign quadrants, round-trip extremes,
// overflow saturation, divide by zero, backpressure and mid-operation reset.
module tb_div64by32s_seq;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    div64by32s_seq_if bus ();

    div64by32s_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Presents one operand pair for a single accept edge, then scrambles the operand bus.
    task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dsr);
        @(negedge clk);
        bus.dividend = dvd;
        bus.divisor  = dsr;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = 64'hDEAD_BEEF_0BAD_F00D;
        bus.divisor  = 32'h0000_0003;
    endtask

    task automatic waitForResult(input string tag);
        int lat;
        bit sawReady;
        lat = 0;
        sawReady = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.in_ready) sawReady = 1'b1;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'd65);
        checkOutput({tag, " in_ready low"}, 64'(sawReady), 64'd0);
    endtask

    task automatic checkResult(input string tag, input logic [31:0] q, input logic [31:0] r,
                               input logic ovf, input logic dbz);
        checkOutput({tag, " quotient"}, 64'(bus.quotient), 64'(q));
        checkOutput({tag, " remainder"}, 64'(bus.remainder), 64'(r));
        checkOutput({tag, " overflow"}, 64'(bus.overflow), 64'(ovf));
        checkOutput({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(dbz));
    endtask

    task automatic releaseResult(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, " out_valid after handshake"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, " in_ready after handshake"}, 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic runVector(input string tag, input logic [63:0] dvd, input logic [31:0] dsr,
                             input logic [31:0] q, input logic [31:0] r, input logic ovf, input logic dbz);
        applyStimulus(dvd, dsr);
        waitForResult(tag);
        checkResult(tag, q, r, ovf, dbz);
        releaseResult(tag);
    endtask

    initial begin
        bit stableOk;
        bit sawValid;
        checkCount    = 0;
        errorCount    = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = 64'd0;
        bus.divisor   = 32'd0;
        rst_n         = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkResult("reset", 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        runVector("100/7",   64'd100,                 32'd7,           32'd14,          32'd2,           1'b0, 1'b0);
        runVector("-100/7",  64'hFFFF_FFFF_FFFF_FF9C, 32'd7,           32'hFFFF_FFF2,   32'hFFFF_FFFE,   1'b0, 1'b0);
        runVector("100/-7",  64'd100,                 32'hFFFF_FFF9,   32'hFFFF_FFF2,   32'd2,           1'b0, 1'b0);
        runVector("-100/-7", 64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9,   32'd14,          32'hFFFF_FFFE,   1'b0, 1'b0);
        runVector("rt min*min",  64'h4000_0000_0000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        runVector("rt min*-1",   64'h0000_0000_8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        runVector("rt max*max",  64'h3FFF_FFFF_0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0);
        runVector("ovf 2^32/1",  64'h0000_0001_0000_0000, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0);
        runVector("ovf -2^32/1", 64'hFFFF_FFFF_0000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        runVector("ovf 2^31/1",  64'h0000_0000_8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0);
        runVector("dbz",         64'h0000_0001_2345_6789, 32'd0, 32'hFFFF_FFFF, 32'h2345_6789, 1'b0, 1'b1);

        // Hold the result in DONE and try to sneak in a new request.
        applyStimulus(64'd100, 32'd7);
        waitForResult("bp");
        stableOk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.quotient !== 32'd14 || bus.remainder !== 32'd2)
                stableOk = 1'b0;
            if (i == 4) begin
                bus.dividend = 64'd50;
                bus.divisor  = 32'd5;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("bp hold stable", 64'(stableOk), 64'd1);
        checkResult("bp", 32'd14, 32'd2, 1'b0, 1'b0);
        releaseResult("bp");

        // Abort an operation mid-CALC with reset.
        applyStimulus(64'hFFFF_FFFF_FFFF_FF9C, 32'd7);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("abort in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("abort quotient cleared", 64'(bus.quotient), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) sawValid = 1'b1;
        end
        checkOutput("abort no stray result", 64'(sawValid), 64'd0);

        runVector("post-reset 100/7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/div64by32s_seq.md
# div64by32s_seq

Sequential signed divider that inverts the registered 32x32 signed multiplier path. It takes a 64-bit signed dividend (a product-width operand) and a 32-bit signed divisor, and returns a 32-bit quotient and a 32-bit remainder with truncate-toward-zero semantics. It is a radix-2 restoring iterative core with valid/ready handshakes on both sides. It sits beside the multiplier wrappers for round-trip checking and for datapaths that need division.

## Interface
- No parameters; widths are fixed at 64/32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  core idle, can accept; equals (state==IDLE)
- dividend  in  64  signed dividend
- divisor  in  32  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  32  signed quotient, saturated on overflow
- remainder  out  32  signed remainder; sign follows the dividend
- overflow  out  1  true quotient not representable in signed 32 bits
- div_by_zero  out  1  divisor was 0

## Operation
- States and transitions:
  - IDLE → CALC on in_valid & in_ready.
  - CALC → FIX after 64 iterations.
  - FIX → DONE after 1 cycle.
  - DONE → IDLE on out_valid & out_ready.
- Accept edge captures:
  - |dividend| as 64-bit unsigned; |divisor| as 32-bit unsigned (-2^31 maps to 2^31).
  - sign_q = dividend[63]^divisor[31]; sign_r = dividend[63].
  - dbz = (divisor==0); iteration counter = 0.
- CALC, once per cycle for 64 cycles:
  - Shift the 33-bit partial remainder left, inserting the next dividend MSB.
  - Subtract |divisor|; if the result is non-negative, keep it and shift in a quotient bit of 1, else restore and shift in 0.
  - Result: 64-bit magnitude quotient Qm and magnitude remainder Rm < |divisor|.
- FIX rules:
  - If dbz: quotient=32'hFFFFFFFF, remainder=dividend[31:0] (captured), div_by_zero=1, overflow=0.
  - Else if sign_q=0 and Qm > 2^31-1: quotient=32'h7FFFFFFF, overflow=1.
  - Else if sign_q=1 and Qm > 2^31: quotient=32'h80000000, overflow=1.
  - Else quotient = sign_q ? -Qm[31:0] : Qm[31:0], overflow=0.
  - remainder = sign_r ? -Rm : Rm in all non-dbz cases, including overflow. The true remainder always fits in 32 bits.
- Round-trip guarantee: for any a, b with b != 0, dividing the product a*b by b returns q=a, r=0, overflow=0.

## Timing
- Fixed latency: out_valid rises 65 clock edges after the accept edge (64 CALC + 1 FIX). Division by zero and overflow take the same latency.
- in_ready is low from the accept edge until the cycle after the output handshake. in_valid is ignored whenever in_ready is low.
- In DONE, quotient, remainder and the flags hold stable while out_ready is low.
- Output handshake:
  - The DONE → IDLE transition happens on the edge where out_valid & out_ready are both high.
  - out_valid falls and in_ready rises on that edge.
  - The next operation can be accepted in the following cycle, giving a minimum of 67 cycles per operation.
- Result registers keep their last values after the handshake; consumers qualify them with out_valid.
- Reset values (asynchronous, while rst_n is low):
  - state=IDLE, so in_ready=1.
  - out_valid=0, quotient=0, remainder=0, overflow=0, div_by_zero=0; the counter and working registers are cleared.
- Reset asserted mid-operation aborts the operation and discards the result. No out_valid follows. The first edge after deassertion can accept a new operation.
- Operand inputs are sampled only on the accept edge; later changes do not affect the operation in flight.

## Test plan
- 100/7 → q=14, r=2, flags 0. out_valid first sampled high exactly 65 edges after the accept edge; in_ready low throughout.
- Sign quadrants:
  - -100/7 → q=32'hFFFFFFF2, r=32'hFFFFFFFE.
  - 100/-7 → q=32'hFFFFFFF2, r=2.
  - -100/-7 → q=14, r=32'hFFFFFFFE.
- Round-trip extremes:
  - 64'h4000000000000000 / 32'h80000000 → q=32'h80000000, r=0, overflow=0.
  - 64'h0000000080000000 / 32'hFFFFFFFF → q=32'h80000000, overflow=0.
- Overflow:
  - 64'h0000000100000000 / 1 → q=32'h7FFFFFFF, r=0, overflow=1.
  - 64'hFFFFFFFF00000000 / 1 → q=32'h80000000, overflow=1.
  - 64'h0000000080000000 / 1 → q=32'h7FFFFFFF, overflow=1.
- Divide by zero: 64'h0000000123456789 / 0 → div_by_zero=1, q=32'hFFFFFFFF, r=32'h23456789, overflow=0; latency still 65.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, a pulsed in_valid is ignored.
  - Then assert rst_n low 30 cycles into a new CALC → out_valid=0 and in_ready=1 immediately, and no stray result appears.
  - A following 100/7 returns q=14, r=2.
